// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_stage
//  Purpose  : Execute/memory stage data-memory controller. Non-memory
//             instructions pass straight through to the Exe/Mem->WB register
//             with zero latency. Loads and stores run as req/ack transactions
//             on the data RAM. stall_out stays high until the access
//             completes, and the result is presented for one DONE cycle.
//  Optional : MEM_TIMEOUT_EN - when defined, an ACCESS phase that lasts
//             TIMEOUT cycles without ram_ack is abandoned. The DONE cycle then
//             carries no writeback, and mem_err is set.
//  Ports    : clk, reset           - clock, synchronous active-high reset
//             in_valid, *_in       - instruction from the execute stage
//             *_out (except stall) - inputs of the WB pipeline register
//             stall_out            - holds upstream stages and the WB register
//             ram_req/we/addr/wdata, ram_rdata/ack - data RAM handshake
//             mem_err              - sticky error flag
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int DATA_W  = 10,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic              mem_re_in,
    input  logic              mem_we_in,
    input  logic              gp_reg_wb_in,
    input  logic [2:0]        gp_rdata2_address_in,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] ram_rdata_out,
    output logic              gp_reg_wb_out,
    output logic              mem_re_out,
    output logic [2:0]        gp_rdata2_address_out,
    output logic              stall_out,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic              mem_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next;

    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_re;
    logic              r_we;
    logic              r_wb;
    logic [2:0]        r_rt;
    logic              r_err;

    logic              w_accept;
    logic              w_ack;
    logic              w_timeout;
    logic              w_timed_out;

    assign w_accept = (r_state == S_IDLE) && in_valid && (mem_re_in || mem_we_in);
    // Acks outside ACCESS are stray pulses and must not touch state.
    assign w_ack    = (r_state == S_ACCESS) && ram_ack;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic          r_timed_out;

    // Fires in the TIMEOUT-th ACCESS cycle; an ack in that same cycle wins.
    assign w_timeout   = (r_state == S_ACCESS) && !ram_ack && (r_cnt == CW'(TIMEOUT - 1));
    assign w_timed_out = r_timed_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_timed_out <= 1'b0;
        end else if (w_accept) begin
            r_cnt       <= '0;
            r_timed_out <= 1'b0;
        end else begin
            if (r_state == S_ACCESS) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_timed_out <= 1'b1;
            end
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_timed_out      = 1'b0;
    assign w_unused_timeout = (TIMEOUT == 0);
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_ACCESS;
            S_ACCESS: if (ram_ack || w_timeout) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Instruction latches, load data capture, sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_re    <= 1'b0;
            r_we    <= 1'b0;
            r_wb    <= 1'b0;
            r_rt    <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu   <= alu_result_in;
                r_wdata <= store_data_in;
                r_re    <= mem_re_in;
                // A load+store encoding is executed as a load only.
                r_we    <= mem_we_in && !mem_re_in;
                r_wb    <= gp_reg_wb_in;
                r_rt    <= gp_rdata2_address_in;
                r_rdata <= '0;
                if (mem_re_in && mem_we_in) begin
                    r_err <= 1'b1;
                end
            end
            if (w_ack) begin
                r_rdata <= r_re ? ram_rdata : '0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic (everything forced low while reset is asserted)
    // ------------------------------------------------------------------
    always_comb begin
        alu_result_out        = '0;
        ram_rdata_out         = '0;
        gp_reg_wb_out         = 1'b0;
        mem_re_out            = 1'b0;
        gp_rdata2_address_out = '0;
        stall_out             = 1'b0;
        ram_req               = 1'b0;
        ram_we                = 1'b0;
        ram_addr              = '0;
        ram_wdata             = '0;
        mem_err               = 1'b0;
        if (!reset) begin
            mem_err = r_err;
            case (r_state)
                S_IDLE: begin
                    alu_result_out        = alu_result_in;
                    gp_rdata2_address_out = gp_rdata2_address_in;
                    if (in_valid) begin
                        gp_reg_wb_out = gp_reg_wb_in;
                        mem_re_out    = mem_re_in;
                        stall_out     = mem_re_in || mem_we_in;
                    end
                end
                S_ACCESS: begin
                    stall_out             = 1'b1;
                    ram_req               = 1'b1;
                    ram_we                = r_we;
                    ram_addr              = r_alu[ADDR_W-1:0];
                    ram_wdata             = r_wdata;
                    alu_result_out        = r_alu;
                    gp_rdata2_address_out = r_rt;
                end
                S_DONE: begin
                    alu_result_out        = r_alu;
                    ram_rdata_out         = r_rdata;
                    gp_reg_wb_out         = r_wb && !w_timed_out;
                    mem_re_out            = r_re;
                    gp_rdata2_address_out = r_rt;
                end
                default: begin
                    stall_out = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_stage
//  Purpose  : Self-checking bench for mem_access_stage. Each memory
//             instruction is described as a transaction timeline. The cycle
//             offset from issue defines what the outputs must show, and a
//             negedge compare process checks the DUT every cycle. Define
//             MEM_TIMEOUT_EN on both files to cover the timeout behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    localparam int DW = 10;
    localparam int AW = 10;
    localparam int TO = 4;

    localparam int M_NONE  = -1;
    localparam int M_RST   = 0;
    localparam int M_IDLE  = 1;
    localparam int M_ISSUE = 2;
    localparam int M_ACC   = 3;
    localparam int M_DONE  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] alu_result_in;
    logic [DW-1:0] store_data_in;
    logic          mem_re_in;
    logic          mem_we_in;
    logic          gp_reg_wb_in;
    logic [2:0]    gp_rdata2_address_in;
    logic [DW-1:0] alu_result_out;
    logic [DW-1:0] ram_rdata_out;
    logic          gp_reg_wb_out;
    logic          mem_re_out;
    logic [2:0]    gp_rdata2_address_out;
    logic          stall_out;
    logic          ram_req;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          ram_ack;
    logic          mem_err;

    always #5 clk = ~clk;

    mem_access_stage #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .TIMEOUT(TO)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .in_valid             (in_valid),
        .alu_result_in        (alu_result_in),
        .store_data_in        (store_data_in),
        .mem_re_in            (mem_re_in),
        .mem_we_in            (mem_we_in),
        .gp_reg_wb_in         (gp_reg_wb_in),
        .gp_rdata2_address_in (gp_rdata2_address_in),
        .alu_result_out       (alu_result_out),
        .ram_rdata_out        (ram_rdata_out),
        .gp_reg_wb_out        (gp_reg_wb_out),
        .mem_re_out           (mem_re_out),
        .gp_rdata2_address_out(gp_rdata2_address_out),
        .stall_out            (stall_out),
        .ram_req              (ram_req),
        .ram_we               (ram_we),
        .ram_addr             (ram_addr),
        .ram_wdata            (ram_wdata),
        .ram_rdata            (ram_rdata),
        .ram_ack              (ram_ack),
        .mem_err              (mem_err)
    );

    int total = 0;
    int bad   = 0;

    // Expected values for the current cycle
    int            mode = M_NONE;
    logic [DW-1:0] e_alu, e_rdata, e_wdata;
    logic [AW-1:0] e_addr;
    logic [2:0]    e_rt;
    logic          e_wb, e_re, e_req, e_we, e_stall, e_err;

    // Observations used by the hand-computed literal checks
    int            n_stall = 0;
    logic [DW-1:0] done_rdata, last_alu, acc_wdata;
    logic          done_re, done_wb, last_wb, acc_we;
    logic [2:0]    last_rt;
    logic [AW-1:0] acc_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    // Single compare process
    always @(negedge clk) begin
        if (mode != M_NONE) begin
            if (stall_out) n_stall++;
            chk("stall_out", stall_out, e_stall);
            chk("ram_req", ram_req, e_req);
            chk("mem_err", mem_err, e_err);
            if (mode == M_RST || mode == M_IDLE || mode == M_DONE) begin
                chk("alu_result_out", alu_result_out, e_alu);
                chk("ram_rdata_out", ram_rdata_out, e_rdata);
                chk("gp_reg_wb_out", gp_reg_wb_out, e_wb);
                chk("mem_re_out", mem_re_out, e_re);
                chk("rt_out", gp_rdata2_address_out, e_rt);
            end
            if (mode == M_RST || mode == M_ACC) begin
                chk("ram_we", ram_we, e_we);
                chk("ram_addr", ram_addr, e_addr);
                chk("ram_wdata", ram_wdata, e_wdata);
            end
            if (mode == M_DONE) begin
                done_rdata = ram_rdata_out;
                done_re    = mem_re_out;
                done_wb    = gp_reg_wb_out;
            end
            if (mode == M_IDLE) begin
                last_alu = alu_result_out;
                last_wb  = gp_reg_wb_out;
                last_rt  = gp_rdata2_address_out;
            end
            if (mode == M_ACC) begin
                acc_we    = ram_we;
                acc_addr  = ram_addr;
                acc_wdata = ram_wdata;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        e_alu = '0; e_rdata = '0; e_wdata = '0; e_addr = '0; e_rt = '0;
        e_wb = 1'b0; e_re = 1'b0; e_req = 1'b0; e_we = 1'b0; e_stall = 1'b0;
    endtask

    // One reset cycle with busy-looking inputs: every output must read 0.
    task automatic reset_cycle();
        reset = 1'b1; in_valid = 1'b1; alu_result_in = 10'h123; store_data_in = 10'h2BC;
        mem_re_in = 1'b1; mem_we_in = 1'b0; gp_reg_wb_in = 1'b1; gp_rdata2_address_in = 3'd6;
        ram_ack = 1'b1; ram_rdata = 10'h3C3;
        mode = M_RST; clear_exp(); e_err = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Idle-state cycle without a memory op; ram_ack is pulsed to show it is ignored.
    task automatic idle_cycle(input logic v, input logic [DW-1:0] alu, input logic wb, input logic [2:0] rt);
        in_valid = v; alu_result_in = alu; store_data_in = DW'($urandom);
        mem_re_in = 1'b0; mem_we_in = 1'b0; gp_reg_wb_in = wb; gp_rdata2_address_in = rt;
        ram_ack = 1'b1; ram_rdata = DW'($urandom);
        mode = M_IDLE; clear_exp();
        e_alu = alu; e_rt = rt; e_wb = v && wb;
        tick();
    endtask

    // Memory instruction timeline. ack_cyc = ACCESS cycle (1-based) carrying
    // ram_ack, 0 = never. rst_at != 0 asserts reset at that offset and stops.
    task automatic run_mem(input logic [DW-1:0] alu, input logic [DW-1:0] data,
                           input logic re, input logic we, input logic wb,
                           input logic [2:0] rt, input int ack_cyc,
                           input logic [DW-1:0] rdata, input int rst_at);
        int  last_acc;
        bit  acked;
        acked    = (ack_cyc != 0);
        last_acc = acked ? ack_cyc : TO;
        in_valid = 1'b1; alu_result_in = alu; store_data_in = data;
        mem_re_in = re; mem_we_in = we; gp_reg_wb_in = wb; gp_rdata2_address_in = rt;
        for (int t = 0; t <= last_acc + 1; t++) begin
            // Stray ack in the DONE cycle must be ignored as well.
            ram_ack   = (t != 0) && ((t == ack_cyc) || (t == last_acc + 1));
            ram_rdata = (t == ack_cyc) ? rdata : DW'($urandom);
            clear_exp();
            if (rst_at != 0 && t == rst_at) begin
                reset = 1'b1; mode = M_RST; e_err = 1'b0;
                tick();
                reset = 1'b0;
                return;
            end else if (t == 0) begin
                mode = M_ISSUE; e_stall = 1'b1;
            end else if (t <= last_acc) begin
                mode = M_ACC; e_stall = 1'b1; e_req = 1'b1;
                e_we = we && !re; e_addr = alu[AW-1:0]; e_wdata = data;
            end else begin
                mode = M_DONE; e_alu = alu; e_rt = rt; e_re = re;
                e_wb = acked ? wb : 1'b0;
                e_rdata = (acked && re) ? rdata : '0;
            end
            tick();
            if (t == 0 && re && we) e_err = 1'b1;
            if (t == last_acc && !acked) e_err = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; alu_result_in = '0; store_data_in = '0;
        mem_re_in = 1'b0; mem_we_in = 1'b0; gp_reg_wb_in = 1'b0; gp_rdata2_address_in = '0;
        ram_ack = 1'b0; ram_rdata = '0; e_err = 1'b0;
        tick();
        reset_cycle();
        reset_cycle();

        // Non-memory instruction: zero-latency pass-through
        idle_cycle(1'b1, 10'h155, 1'b1, 3'd3);
        chk("alu_op_result", last_alu, 10'h155);
        chk("alu_op_wb", last_wb, 1'b1);
        chk("alu_op_rt", last_rt, 3'd3);
        idle_cycle(1'b0, 10'h0C7, 1'b1, 3'd1);
        chk("bubble_wb", last_wb, 1'b0);

        // Load, ack in the third ACCESS cycle
        n_stall = 0;
        run_mem(10'h040, 10'h1E1, 1'b1, 1'b0, 1'b1, 3'd5, 3, 10'h2A5, 0);
        chk("load_stall_cycles", n_stall, 4);
        chk("load_addr", acc_addr, 10'h040);
        chk("load_we", acc_we, 1'b0);
        chk("load_rdata", done_rdata, 10'h2A5);
        chk("load_re", done_re, 1'b1);
        idle_cycle(1'b1, 10'h2D2, 1'b0, 3'd0);

        // Store, ack in the first ACCESS cycle
        n_stall = 0;
        run_mem(10'h001, 10'h3FF, 1'b0, 1'b1, 1'b0, 3'd4, 1, 10'h0AB, 0);
        chk("store_stall_cycles", n_stall, 2);
        chk("store_we", acc_we, 1'b1);
        chk("store_wdata", acc_wdata, 10'h3FF);
        chk("store_wb", done_wb, 1'b0);
        chk("store_rdata", done_rdata, 10'h000);
        idle_cycle(1'b0, 10'h011, 1'b0, 3'd7);

        // Load and store together: executed as a load, error is sticky
        run_mem(10'h07F, 10'h155, 1'b1, 1'b1, 1'b1, 3'd2, 2, 10'h111, 0);
        chk("both_we", acc_we, 1'b0);
        chk("both_rdata", done_rdata, 10'h111);
        idle_cycle(1'b1, 10'h003, 1'b1, 3'd2);
        idle_cycle(1'b0, 10'h004, 1'b0, 3'd2);
        chk("err_sticky", mem_err, 1'b1);

        // Reset in the second ACCESS cycle, then a late ack
        run_mem(10'h0AA, 10'h022, 1'b1, 1'b0, 1'b1, 3'd1, 0, 10'h0FF, 2);
        idle_cycle(1'b0, 10'h0AA, 1'b0, 3'd1);
        chk("rst_abort_req", ram_req, 1'b0);
        chk("rst_abort_err", mem_err, 1'b0);
        idle_cycle(1'b1, 10'h2AA, 1'b1, 3'd6);

`ifdef MEM_TIMEOUT_EN
        // Ack coincident with the timeout: normal completion
        run_mem(10'h100, 10'h000, 1'b1, 1'b0, 1'b1, 3'd3, TO, 10'h0F0, 0);
        chk("to_race_rdata", done_rdata, 10'h0F0);
        chk("to_race_err", mem_err, 1'b0);
        idle_cycle(1'b0, 10'h000, 1'b0, 3'd0);
        // No ack at all: abandoned after TO ACCESS cycles
        n_stall = 0;
        run_mem(10'h200, 10'h000, 1'b1, 1'b0, 1'b1, 3'd3, 0, 10'h000, 0);
        chk("to_stall_cycles", n_stall, 5);
        chk("to_wb", done_wb, 1'b0);
        chk("to_rdata", done_rdata, 10'h000);
        chk("to_err", mem_err, 1'b1);
        idle_cycle(1'b0, 10'h000, 1'b0, 3'd0);
`endif

        mode = M_NONE;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
